hella_cache_slave: RTL and testbench

HELLA_CACHE_SLAVE -- requirements
Module: hella_cache_slave

---
 rtl/hella_cache_pkg.sv | 57 +++++
 rtl/hella_cache_slave_mem.sv | 27 ++
 rtl/hella_cache_slave.sv | 149 ++++++++++++++
 tb/tb_hella_cache_slave.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/hella_cache_pkg.sv
// Shared definitions for the hella cache slave and its master BFM:
// command codes, typ size encodings and byte-lane helpers.
package hella_cache_pkg;

  localparam logic [4:0] M_XRD = 5'd0;
  localparam logic [4:0] M_XWR = 5'd1;

  typedef enum logic [1:0] {
    MT_B = 2'd0,
    MT_H = 2'd1,
    MT_W = 2'd2,
    MT_X = 2'd3
  } mem_size_e;

  localparam int TYP_UNSIGNED_BIT = 2;

  // Per-request state carried down the pipeline (width-independent part).
  typedef struct packed {
    logic        nack;
    logic        store;
    logic [1:0]  off;
    logic [2:0]  typ;
    logic [3:0]  be;
    logic [31:0] wdata;
  } stage_t;

  function automatic logic [3:0] lane_mask(input mem_size_e size, input logic [1:0] off);
    case (size)
      MT_B:    lane_mask = 4'b0001 << off;
      MT_H:    lane_mask = 4'b0011 << off;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic misaligned(input mem_size_e size, input logic [1:0] off);
    misaligned = ((size == MT_H) && off[0]) || ((size == MT_W) && (off != 2'd0));
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input mem_size_e size,
                                              input logic [1:0] off, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      MT_B:    load_extend = uns ? {24'd0, b} : {{24{b[7]}}, b};
      MT_H:    load_extend = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: load_extend = word;
    endcase
  endfunction

endpackage

// File: rtl/hella_cache_slave_mem.sv
// Word RAM with one registered read port and one byte-enabled write port.
// Contents are deliberately not reset so they survive a pipeline reset.
module hella_cache_slave_mem
  #(parameter int WORDS_LOG2 = 8)
  (
    input  logic                  clock,
    input  logic [WORDS_LOG2-1:0] rd_addr,
    output logic [31:0]           rd_data,
    input  logic                  wr_en,
    input  logic [WORDS_LOG2-1:0] wr_addr,
    input  logic [3:0]            wr_be,
    input  logic [31:0]           wr_data
  );

  logic [31:0] mem [0:(1<<WORDS_LOG2)-1];

  // Read returns the pre-write value on a same-word collision.
  always_ff @(posedge clock) begin
    rd_data <= mem[rd_addr];
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/hella_cache_slave.sv
// Three-stage hella cache slave: S0 accept/decode, S1 kill check and RAM read,
// S2 write commit and response. Store-to-load forwarding covers S2->S1.
module hella_cache_slave
  import hella_cache_pkg::*;
  #(
    parameter int NUM_ADDR_BITS  = 32,
    parameter int NUM_DATA_BITS  = 32,
    parameter int NUM_TAG_BITS   = 7,
    parameter int MEM_WORDS_LOG2 = 8,
    parameter int READY_GAP      = 0
  )
  (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [NUM_ADDR_BITS-1:0]   req_addr,
    output logic                       req_ready,
    input  logic                       req_valid,
    input  logic [NUM_TAG_BITS-1:0]    req_tag,
    input  logic [4:0]                 req_cmd,
    input  logic [2:0]                 req_typ,
    input  logic [NUM_DATA_BITS-1:0]   req_data,
    input  logic [NUM_DATA_BITS/8-1:0] req_data_mask,
    input  logic                       req_kill,
    output logic                       rsp_valid,
    output logic                       rsp_nack,
    output logic [NUM_TAG_BITS-1:0]    rsp_tag,
    output logic [2:0]                 rsp_typ,
    output logic [NUM_DATA_BITS-1:0]   rsp_data
  );

  if (NUM_DATA_BITS != 32) begin : g_bad_data_width
    $error("hella_cache_slave: NUM_DATA_BITS must be 32");
  end

  localparam int GAP_W  = (READY_GAP > 0) ? $clog2(READY_GAP + 1) : 1;
  localparam int WORD_W = MEM_WORDS_LOG2;

  // Handshake: a request transfers on a rising edge with req_valid && req_ready;
  // req_ready never depends on req_valid, and responses cannot be stalled.
  logic             ready_q;
  logic [GAP_W-1:0] gap_cnt;
  logic             accept;

  logic             s1_valid, s2_valid;
  stage_t           s0_info, s1_info, s2_info;
  logic [WORD_W-1:0] s0_word, s1_word, s2_word;
  logic [NUM_TAG_BITS-1:0] s1_tag, s2_tag;
  logic [3:0]       s2_fwd_be;
  logic [31:0]      s2_fwd_data;

  mem_size_e        s0_size;
  logic [1:0]       s0_off;
  logic [63:0]      addr_ext;
  logic             s0_bad;
  logic             commit;
  logic [31:0]      mem_rd_data;
  logic [31:0]      merged;
  logic [31:0]      load_data;
  logic             unused_inputs;

  assign unused_inputs = ^req_data_mask;

  assign req_ready = ready_q && (gap_cnt == '0);
  assign accept    = req_valid && req_ready;

  assign s0_size  = mem_size_e'(req_typ[1:0]);
  assign s0_off   = req_addr[1:0];
  assign s0_word  = req_addr[MEM_WORDS_LOG2+1:2];
  assign addr_ext = 64'(req_addr);

  always_comb begin
    s0_bad = ((req_cmd != M_XRD) && (req_cmd != M_XWR)) ||
             (s0_size == MT_X) ||
             misaligned(s0_size, s0_off) ||
             (addr_ext >= (64'd4 << MEM_WORDS_LOG2));
    s0_info       = '0;
    s0_info.nack  = s0_bad;
    s0_info.store = (req_cmd == M_XWR);
    s0_info.off   = s0_off;
    s0_info.typ   = req_typ;
    s0_info.be    = lane_mask(s0_size, s0_off);
    s0_info.wdata = req_data << {s0_off, 3'b000};
  end

  assign commit = s2_valid && !s2_info.nack && s2_info.store;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ready_q     <= 1'b0;
      gap_cnt     <= '0;
      s1_valid    <= 1'b0;
      s1_info     <= '0;
      s1_word     <= '0;
      s1_tag      <= '0;
      s2_valid    <= 1'b0;
      s2_info     <= '0;
      s2_word     <= '0;
      s2_tag      <= '0;
      s2_fwd_be   <= '0;
      s2_fwd_data <= '0;
    end else begin
      ready_q <= 1'b1;
      if (accept) gap_cnt <= GAP_W'(READY_GAP);
      else if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;

      s1_valid <= accept;
      if (accept) begin
        s1_info <= s0_info;
        s1_word <= s0_word;
        s1_tag  <= req_tag;
      end

      s2_valid <= s1_valid && !req_kill;
      s2_info  <= s1_info;
      s2_word  <= s1_word;
      s2_tag   <= s1_tag;
      // The RAM read in S1 misses the store committing in the same cycle,
      // so remember its bytes and merge them into the read data in S2.
      s2_fwd_be   <= (commit && (s2_word == s1_word)) ? s2_info.be : 4'b0000;
      s2_fwd_data <= s2_info.wdata;
    end
  end

  hella_cache_slave_mem #(.WORDS_LOG2(MEM_WORDS_LOG2)) u_mem (
    .clock   (clock),
    .rd_addr (s1_word),
    .rd_data (mem_rd_data),
    .wr_en   (commit),
    .wr_addr (s2_word),
    .wr_be   (s2_info.be),
    .wr_data (s2_info.wdata)
  );

  always_comb begin
    merged = mem_rd_data;
    for (int i = 0; i < 4; i++) begin
      if (s2_fwd_be[i]) merged[8*i +: 8] = s2_fwd_data[8*i +: 8];
    end
    load_data = load_extend(merged, mem_size_e'(s2_info.typ[1:0]), s2_info.off,
                            s2_info.typ[TYP_UNSIGNED_BIT]);
  end

  assign rsp_valid = s2_valid && !s2_info.nack;
  assign rsp_nack  = s2_valid && s2_info.nack;
  assign rsp_tag   = s2_valid ? s2_tag : '0;
  assign rsp_typ   = s2_valid ? s2_info.typ : 3'd0;
  assign rsp_data  = (rsp_valid && !s2_info.store) ? load_data : '0;

endmodule

// File: tb/tb_hella_cache_slave.sv
// Directed bench for hella_cache_slave: loads/stores, forwarding, kill, nacks,
// ready gap spacing and mid-operation reset, checked through an expected queue.
module tb_hella_cache_slave;
  import hella_cache_pkg::*;

  localparam int EW = 43;

  // clock / reset
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // main instance, READY_GAP = 0
  logic [31:0] req_addr = '0;
  logic        req_ready;
  logic        req_valid = 1'b0;
  logic [6:0]  req_tag = '0;
  logic [4:0]  req_cmd = '0;
  logic [2:0]  req_typ = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_data_mask = '0;
  logic        req_kill = 1'b0;
  logic        rsp_valid, rsp_nack;
  logic [6:0]  rsp_tag;
  logic [2:0]  rsp_typ;
  logic [31:0] rsp_data;

  hella_cache_slave dut (
    .clock(clock), .reset_n(reset_n), .req_addr(req_addr), .req_ready(req_ready),
    .req_valid(req_valid), .req_tag(req_tag), .req_cmd(req_cmd), .req_typ(req_typ),
    .req_data(req_data), .req_data_mask(req_data_mask), .req_kill(req_kill),
    .rsp_valid(rsp_valid), .rsp_nack(rsp_nack), .rsp_tag(rsp_tag), .rsp_typ(rsp_typ),
    .rsp_data(rsp_data)
  );

  // gap instance, READY_GAP = 2
  logic        g_req_ready;
  logic        g_req_valid = 1'b0;
  logic        g_req_kill = 1'b0;
  logic        g_rsp_valid, g_rsp_nack;
  logic [6:0]  g_rsp_tag;
  logic [2:0]  g_rsp_typ;
  logic [31:0] g_rsp_data;

  hella_cache_slave #(.READY_GAP(2)) dut_gap (
    .clock(clock), .reset_n(reset_n), .req_addr(32'h0), .req_ready(g_req_ready),
    .req_valid(g_req_valid), .req_tag(7'd0), .req_cmd(M_XRD), .req_typ(3'd2),
    .req_data(32'h0), .req_data_mask(4'h0), .req_kill(g_req_kill),
    .rsp_valid(g_rsp_valid), .rsp_nack(g_rsp_nack), .rsp_tag(g_rsp_tag), .rsp_typ(g_rsp_typ),
    .rsp_data(g_rsp_data)
  );

  // scoreboard
  int n_checks = 0;
  int n_pass = 0;
  logic [EW-1:0] exp_q[$];
  int exp_cyc_q[$];
  int rsp_cnt = 0;
  int g_rsp_cnt = 0;
  logic pending_kill = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
  endtask

  always @(negedge clock) begin
    if (reset_n && (rsp_valid || rsp_nack)) begin
      rsp_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", {62'd0, rsp_valid, rsp_nack}, 64'd0);
      end else begin
        logic [EW-1:0] e;
        int ec;
        e = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check($sformatf("rsp_fields_tag%0d", e[41:35]),
              64'({rsp_nack, rsp_tag, rsp_typ, rsp_data}), 64'(e));
        check("rsp_valid", 64'(rsp_valid), 64'(!e[EW-1]));
        check("rsp_latency", 64'(cyc), 64'(ec));
      end
    end
  end

  always @(negedge clock) begin
    if (reset_n && (g_rsp_valid || g_rsp_nack)) g_rsp_cnt++;
  end

  // driver tasks
  task automatic drive(input logic [4:0] cmd, input logic [2:0] typ, input logic [31:0] addr,
                       input logic [31:0] data, input logic [6:0] tag, input logic kill_after,
                       input logic exp_nack, input logic [31:0] exp_data);
    int waited = 0;
    @(negedge clock);
    req_kill = pending_kill;
    pending_kill = kill_after;
    req_valid = 1'b1;
    req_cmd = cmd;
    req_typ = typ;
    req_addr = addr;
    req_data = data;
    req_tag = tag;
    while (!req_ready && waited < 20) begin
      @(negedge clock);
      req_kill = 1'b0;
      waited++;
    end
    if (!req_ready) begin
      check("ready_timeout", 64'(req_ready), 64'd1);
      req_valid = 1'b0;
    end else if (!kill_after) begin
      exp_q.push_back({exp_nack, tag, typ, exp_data});
      exp_cyc_q.push_back(cyc + 2);
    end
    @(posedge clock);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      req_valid = 1'b0;
      req_kill = pending_kill;
      pending_kill = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rsp_before;
    int drain;

    // reset values
    repeat (2) @(negedge clock);
    check("reset_req_ready", 64'(req_ready), 64'd0);
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_rsp_nack", 64'(rsp_nack), 64'd0);
    check("reset_rsp_tag", 64'(rsp_tag), 64'd0);
    check("reset_rsp_data", 64'(rsp_data), 64'd0);
    check("reset_gap_ready", 64'(g_req_ready), 64'd0);
    reset_n = 1'b1;
    #1 check("ready_at_release", 64'(req_ready), 64'd0);
    @(posedge clock);
    #1 check("ready_after_release", 64'(req_ready), 64'd1);

    // stores, loads and forwarding
    drive(M_XWR, 3'd2, 32'h10, 32'hDEADBEEF, 7'd1, 1'b0, 1'b0, 32'h0);
    drive(M_XRD, 3'd2, 32'h10, 32'h0, 7'd2, 1'b0, 1'b0, 32'hDEADBEEF);
    drive(M_XRD, 3'd0, 32'h13, 32'h0, 7'd3, 1'b0, 1'b0, 32'hFFFFFFDE);
    drive(M_XRD, 3'd4, 32'h13, 32'h0, 7'd4, 1'b0, 1'b0, 32'h000000DE);
    drive(M_XRD, 3'd1, 32'h12, 32'h0, 7'd8, 1'b0, 1'b0, 32'hFFFFDEAD);
    drive(M_XWR, 3'd0, 32'h11, 32'hAAAAAA77, 7'd9, 1'b0, 1'b0, 32'h0);
    drive(M_XRD, 3'd2, 32'h10, 32'h0, 7'd10, 1'b0, 1'b0, 32'hDEAD77EF);
    drive(M_XRD, 3'd5, 32'h10, 32'h0, 7'd11, 1'b0, 1'b0, 32'h000077EF);
    drive(M_XRD, 3'd0, 32'h11, 32'h0, 7'd12, 1'b0, 1'b0, 32'h00000077);

    // killed store leaves prior contents
    drive(M_XWR, 3'd2, 32'h20, 32'hA5A5A5A5, 7'd20, 1'b0, 1'b0, 32'h0);
    drive(M_XWR, 3'd2, 32'h20, 32'h11111111, 7'd21, 1'b1, 1'b0, 32'h0);
    drive(M_XRD, 3'd2, 32'h20, 32'h0, 7'd22, 1'b0, 1'b0, 32'hA5A5A5A5);

    // nacks, then memory unchanged
    drive(M_XRD, 3'd1, 32'h11, 32'h0, 7'd5, 1'b0, 1'b1, 32'h0);
    drive(5'd3, 3'd2, 32'h20, 32'h0, 7'd6, 1'b0, 1'b1, 32'h0);
    drive(M_XRD, 3'd2, 32'h400, 32'h0, 7'd7, 1'b0, 1'b1, 32'h0);
    drive(M_XWR, 3'd2, 32'h22, 32'hFFFFFFFF, 7'd23, 1'b0, 1'b1, 32'h0);
    drive(M_XWR, 3'd3, 32'h20, 32'hFFFFFFFF, 7'd24, 1'b0, 1'b1, 32'h0);
    drive(M_XRD, 3'd2, 32'h20, 32'h0, 7'd25, 1'b0, 1'b0, 32'hA5A5A5A5);

    // highest in-range word
    drive(M_XWR, 3'd2, 32'h3FC, 32'h12345678, 7'd26, 1'b0, 1'b0, 32'h0);
    idle(1);
    drive(M_XRD, 3'd2, 32'h3FC, 32'h0, 7'd27, 1'b0, 1'b0, 32'h12345678);
    idle(4);

    // READY_GAP=2 spacing; first accepted request is killed but keeps its slot
    @(negedge clock);
    g_req_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      g_req_kill = (i == 1);
      check($sformatf("gap_ready_%0d", i), 64'(g_req_ready), 64'(i % 3 == 0));
      @(negedge clock);
    end
    g_req_valid = 1'b0;
    g_req_kill = 1'b0;
    repeat (4) @(negedge clock);
    check("gap_rsp_count", 64'(g_rsp_cnt), 64'd2);

    // reset with a load in S1
    rsp_before = rsp_cnt;
    req_valid = 1'b1;
    req_cmd = M_XRD;
    req_typ = 3'd2;
    req_addr = 32'h10;
    req_tag = 7'd30;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    reset_n = 1'b0;
    #1 check("midreset_ready", 64'(req_ready), 64'd0);
    check("midreset_rsp_valid", 64'(rsp_valid), 64'd0);
    @(negedge clock);
    check("midreset_rsp_nack", 64'(rsp_nack), 64'd0);
    check("midreset_rsp_data", 64'(rsp_data), 64'd0);
    reset_n = 1'b1;
    #1 check("midreset_ready_release", 64'(req_ready), 64'd0);
    @(posedge clock);
    #1 check("midreset_ready_after", 64'(req_ready), 64'd1);
    repeat (4) @(negedge clock);
    check("midreset_no_rsp", 64'(rsp_cnt), 64'(rsp_before));

    // memory retained across reset
    drive(M_XRD, 3'd2, 32'h10, 32'h0, 7'd31, 1'b0, 1'b0, 32'hDEAD77EF);
    idle(1);
    drain = 0;
    while (exp_q.size() != 0 && drain < 20) begin
      @(negedge clock);
      drain++;
    end
    @(negedge clock);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
